// File: rtl/reg_bank_gen2_pkg.sv
// Shared types and constants for the layer configuration register bank.
// Region enum, default address map, configuration field indices and the
// address-map overlap check used at elaboration time.
package reg_bank_pkg;

    typedef enum logic [1:0] {REG_RW, REG_RO, REG_CMD, REG_NONE} region_e;

    localparam int STATUS_BASE_DEF = 'h40;
    localparam int CMD_ADDR_DEF    = 'h80;

    // Configuration field slots inside the RW region
    localparam int CFG_DATA_WID = 0;
    localparam int CFG_DATA_HEI = 1;
    localparam int CFG_DATA_CH  = 2;
    localparam int CFG_KERN_SZ  = 3;
    localparam int CFG_STRIDE   = 4;
    localparam int CFG_PAD      = 5;
    localparam int CFG_SRC_BASE = 6;
    localparam int CFG_DST_BASE = 7;

    // True when any two of RW [0,num_rw), RO [base,base+num_ro) and CMD collide
    function automatic bit regions_overlap(int num_rw, int status_base,
                                           int num_ro, int cmd_addr);
        bit ov;
        ov = 1'b0;
        if (num_ro > 0 && status_base < num_rw) ov = 1'b1;
        if (cmd_addr < num_rw) ov = 1'b1;
        if (cmd_addr >= status_base && cmd_addr < status_base + num_ro) ov = 1'b1;
        return ov;
    endfunction

endpackage

// File: rtl/reg_bank_gen2_if.sv
// Host request/response bus for the register bank (valid/ready both ways).
interface reg_bank_gen2_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/reg_bank_gen2_decode.sv
// Combinational address decoder: address -> region plus per-region index.
module reg_bank_decode
    import reg_bank_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int NUM_RW      = 32,
    parameter int STATUS_BASE = STATUS_BASE_DEF,
    parameter int NUM_RO      = 8,
    parameter int CMD_ADDR    = CMD_ADDR_DEF,
    parameter int RW_IW       = 5,
    parameter int RO_IW       = 3
) (
    input  logic [ADDR_W-1:0] addr,
    output region_e           region,
    output logic [RW_IW-1:0]  rw_idx,
    output logic [RO_IW-1:0]  ro_idx
);
    logic [31:0] a32;
    assign a32 = 32'(addr);

    // Regions are disjoint, so the priority order here is only for form
    always_comb begin
        region = REG_NONE;
        if (a32 < 32'(NUM_RW))
            region = REG_RW;
        else if (a32 >= 32'(STATUS_BASE) && a32 < 32'(STATUS_BASE + NUM_RO))
            region = REG_RO;
        else if (a32 == 32'(CMD_ADDR))
            region = REG_CMD;
    end

    assign rw_idx = RW_IW'(a32);
    assign ro_idx = RO_IW'(a32 - 32'(STATUS_BASE));
endmodule

// File: rtl/reg_bank_gen2.sv
// Layer configuration register bank: one host port, RW config / RO status /
// write-1-pulse command regions, flat cfg and pulse vectors to the engines.
// Optional feature macro: REG_BANK_SHADOW_EN -- cfg_o comes from an active
// copy loaded from staging by a commit command; otherwise cfg_o is staging
// and RW writes are refused while the engine is busy.
module reg_bank_gen2
    import reg_bank_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 8,
    parameter int NUM_RW      = 32,
    parameter int STATUS_BASE = STATUS_BASE_DEF,
    parameter int NUM_RO      = 8,
    parameter int CMD_ADDR    = CMD_ADDR_DEF,
    parameter int COMMIT_BIT  = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    reg_bank_gen2_if.slave                 bus,
    input  logic                           busy_i,
    input  logic [NUM_RO-1:0][DATA_W-1:0]  status_i,
    output logic [NUM_RW-1:0][DATA_W-1:0]  cfg_o,
    output logic [DATA_W-1:0]              cmd_pulse_o
);
    localparam int RW_IW = (NUM_RW > 1) ? $clog2(NUM_RW) : 1;
    localparam int RO_IW = (NUM_RO > 1) ? $clog2(NUM_RO) : 1;

    if (regions_overlap(NUM_RW, STATUS_BASE, NUM_RO, CMD_ADDR)) begin : g_map_bad
        $error("reg_bank_gen2: address regions overlap");
    end
    if (COMMIT_BIT >= DATA_W) begin : g_commit_bad
        $error("reg_bank_gen2: COMMIT_BIT outside register width");
    end

    region_e                        region;
    logic [RW_IW-1:0]               rw_idx;
    logic [RO_IW-1:0]               ro_idx;
    logic                           ready_en;
    logic                           rsp_valid_q;
    logic                           rsp_err_q;
    logic [DATA_W-1:0]              rsp_rdata_q;
    logic [DATA_W-1:0]              pulse_q;
    logic [NUM_RW-1:0][DATA_W-1:0]  stg;
    logic                           accept;
    logic                           rw_wr_ok;
    logic                           rw_wr;
    logic                           cmd_wr;
    logic                           rsp_err_d;
    logic [DATA_W-1:0]              rsp_rdata_d;

    reg_bank_decode #(
        .ADDR_W(ADDR_W), .NUM_RW(NUM_RW), .STATUS_BASE(STATUS_BASE),
        .NUM_RO(NUM_RO), .CMD_ADDR(CMD_ADDR), .RW_IW(RW_IW), .RO_IW(RO_IW)
    ) u_dec (
        .addr   (bus.req_addr),
        .region (region),
        .rw_idx (rw_idx),
        .ro_idx (ro_idx)
    );

    // ready_en keeps req_ready low in reset and for no longer than one edge after
    assign bus.req_ready = ready_en && (!rsp_valid_q || bus.rsp_ready);
    assign accept        = bus.req_valid && bus.req_ready;

`ifdef REG_BANK_SHADOW_EN
    assign rw_wr_ok = 1'b1;
`else
    assign rw_wr_ok = !busy_i;
`endif

    assign rw_wr  = accept && bus.req_write && (region == REG_RW) && rw_wr_ok;
    assign cmd_wr = accept && bus.req_write && (region == REG_CMD);

    // Response payload for the request currently on the bus
    always_comb begin
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        case (region)
            REG_RW:  if (bus.req_write) rsp_err_d = !rw_wr_ok;
                     else               rsp_rdata_d = stg[rw_idx];
            REG_RO:  if (bus.req_write) rsp_err_d = 1'b1;
                     else               rsp_rdata_d = status_i[ro_idx];
            REG_CMD: rsp_err_d = 1'b0;
            default: rsp_err_d = 1'b1;
        endcase
    end

    // Single-entry response register; holds until the host takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (accept) begin
                rsp_valid_q <= 1'b1;
                rsp_rdata_q <= rsp_rdata_d;
                rsp_err_q   <= rsp_err_d;
            end else if (bus.rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    // Staging registers, written by the host
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stg <= '0;
        else if (rw_wr)
            stg[rw_idx] <= bus.req_wdata;
    end

    // Command pulse lives exactly one cycle; back-to-back writes chain cleanly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pulse_q <= '0;
        else
            pulse_q <= cmd_wr ? bus.req_wdata : '0;
    end

    assign cmd_pulse_o = pulse_q;

`ifdef REG_BANK_SHADOW_EN
    logic [NUM_RW-1:0][DATA_W-1:0] act;

    // Active copy snaps the whole staging set together with the start pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            act <= '0;
        else if (cmd_wr && bus.req_wdata[COMMIT_BIT])
            act <= stg;
    end

    assign cfg_o = act;
`else
    assign cfg_o = stg;
`endif

endmodule

// File: tb/tb_reg_bank_gen2.sv
// Directed + randomized bench for reg_bank_gen2 against an array-based model.
// Honors REG_BANK_SHADOW_EN to pick the expected configuration behaviour.
module tb_reg_bank_gen2;
    import reg_bank_pkg::*;

`ifdef REG_BANK_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    typedef logic [31:0][15:0] cfg_t;

    logic             clk;
    logic             rst_n;
    logic             busy;
    logic [7:0][15:0] status;
    cfg_t             cfg_o;
    logic [15:0]      cmd_pulse_o;

    int errors = 0;
    int checks = 0;

    logic [15:0] stg_m [32];
    logic [15:0] act_m [32];

    reg_bank_gen2_if #(.ADDR_W(8), .DATA_W(16)) bus ();

    reg_bank_gen2 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .busy_i      (busy),
        .status_i    (status),
        .cfg_o       (cfg_o),
        .cmd_pulse_o (cmd_pulse_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic cfg_t cfg_exp();
        cfg_t e;
        for (int k = 0; k < 32; k++) e[k] = SHADOW ? act_m[k] : stg_m[k];
        return e;
    endfunction

    task automatic chk_cfg(input string tag);
        cfg_t e;
        e = cfg_exp();
        checks++;
        assert (cfg_o === e) else begin
            errors++;
            $error("FAIL %s.cfg: got %0h want %0h", tag, cfg_o, e);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 32; k++) begin
            stg_m[k] = '0;
            act_m[k] = '0;
        end
    endtask

    // Address-map rules applied to one accepted request
    task automatic model(input bit wr, input int a, input logic [15:0] wd,
                         output logic [15:0] rd, output bit er, output logic [15:0] pl);
        rd = '0; er = 1'b0; pl = '0;
        if (a < 32) begin
            if (wr) begin
                if (SHADOW || !busy) stg_m[5'(a)] = wd;
                else                 er = 1'b1;
            end else begin
                rd = stg_m[5'(a)];
            end
        end else if (a >= 'h40 && a < 'h48) begin
            if (wr) er = 1'b1;
            else    rd = status[3'(a - 'h40)];
        end else if (a == 'h80) begin
            if (wr) begin
                pl = wd;
                if (SHADOW && wd[0]) act_m = stg_m;
            end
        end else begin
            er = 1'b1;
        end
    endtask

    // One bus cycle with rsp_ready=1: entered and left at a falling edge
    task automatic step(input bit v, input bit wr, input int a, input logic [15:0] wd,
                        input string tag);
        logic [15:0] rd, pl;
        bit er;
        rd = '0; pl = '0; er = 1'b0;
        bus.req_valid = v;
        bus.req_write = wr;
        bus.req_addr  = 8'(a);
        bus.req_wdata = wd;
        if (v) begin
            #1;
            chk({tag, ".rdy"}, 32'(bus.req_ready), 32'd1);
            model(wr, a, wd, rd, er, pl);
        end
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk({tag, ".vld"}, 32'(bus.rsp_valid), 32'(v));
        if (v) begin
            chk({tag, ".rdata"}, 32'(bus.rsp_rdata), 32'(rd));
            chk({tag, ".err"}, 32'(bus.rsp_err), 32'(er));
        end
        chk({tag, ".pulse"}, 32'(cmd_pulse_o), 32'(pl));
        chk_cfg(tag);
    endtask

    initial begin
        logic [15:0] rd1, pl_d;
        bit er_d;
        int a, r;

        rst_n = 1'b0;
        busy  = 1'b0;
        status = '0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b1;
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst.ready", 32'(bus.req_ready), 0);
        chk("rst.vld", 32'(bus.rsp_valid), 0);
        chk("rst.pulse", 32'(cmd_pulse_o), 0);
        chk_cfg("rst");
        rst_n = 1'b1;
        #1 chk("rel.ready_pre", 32'(bus.req_ready), 0);
        @(posedge clk);
        @(negedge clk);
        chk("rel.ready", 32'(bus.req_ready), 1);

        // Busy write into config word 0, then commit command
        busy = 1'b1;
        step(1, 1, 0, 16'h0010, "busy_wr");
        chk("busy_wr.cfg0", 32'(cfg_o[0]), 0);
        busy = 1'b0;
        step(1, 1, 'h80, 16'h0001, "commit");
        chk("commit.cfg0", 32'(cfg_o[0]), SHADOW ? 32'h10 : 32'h0);

        // RW write then read-back
        step(1, 1, 3, 16'h1234, "wr3");
        step(1, 0, 3, 16'h0000, "rd3");

        // RO region
        status[2] = 16'hBEEF;
        step(1, 0, 'h42, 16'h0000, "rd42");
        step(1, 1, 'h42, 16'h5555, "wr42");

        // Command pulses back-to-back, then idle, then command read
        step(1, 1, 'h80, 16'h0005, "cmd5");
        step(1, 1, 'h80, 16'h0002, "cmd2");
        step(0, 0, 0, 16'h0000, "idle");
        step(1, 0, 'h80, 16'h0000, "cmd_rd");

        // Unmapped addresses
        step(1, 0, 'h7F, 16'h0000, "rd7f");
        step(1, 1, 'hC3, 16'h9999, "wrc3");

        // Response back-pressure
        step(1, 1, 1, 16'h0A0A, "wr1");
        step(0, 0, 0, 16'h0000, "idle2");
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 8'd1;
        #1 chk("stall.rdy0", 32'(bus.req_ready), 1);
        model(0, 1, 16'h0, rd1, er_d, pl_d);
        @(posedge clk);
        @(negedge clk);
        bus.req_write = 1'b1;
        bus.req_addr  = 8'd5;
        bus.req_wdata = 16'hAAAA;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall.vld", 32'(bus.rsp_valid), 1);
            chk("stall.rdata", 32'(bus.rsp_rdata), 32'(rd1));
            chk("stall.ready", 32'(bus.req_ready), 0);
            chk_cfg("stall");
            @(posedge clk);
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        #1 chk("release.ready", 32'(bus.req_ready), 1);
        model(1, 5, 16'hAAAA, rd1, er_d, pl_d);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("release.vld", 32'(bus.rsp_valid), 1);
        chk("release.err", 32'(bus.rsp_err), 32'(er_d));
        chk_cfg("release");
        step(1, 0, 5, 16'h0000, "rd5");

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            busy = 1'($urandom_range(0, 1));
            for (int k = 0; k < 8; k++) status[k] = 16'($urandom);
            r = $urandom_range(0, 9);
            if (r <= 3 || r >= 8) a = $urandom_range(0, 31);
            else if (r <= 5)      a = 'h40 + $urandom_range(0, 7);
            else if (r == 6)      a = 'h80;
            else if ($urandom_range(0, 1) == 1) a = $urandom_range('h20, 'h3F);
            else                  a = $urandom_range('h81, 'hFF);
            step(($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)), a,
                 16'($urandom), "rand");
        end
        busy = 1'b0;

        // Reset while a response and a pulse are in flight
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 8'h80;
        bus.req_wdata = 16'h0007;
        model(1, 'h80, 16'h0007, rd1, er_d, pl_d);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        chk("mid.vld", 32'(bus.rsp_valid), 1);
        chk("mid.pulse", 32'(cmd_pulse_o), 32'h7);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("mid_rst.vld", 32'(bus.rsp_valid), 0);
        chk("mid_rst.pulse", 32'(cmd_pulse_o), 0);
        chk("mid_rst.ready", 32'(bus.req_ready), 0);
        chk_cfg("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst.ready", 32'(bus.req_ready), 1);
        chk("post_rst.vld", 32'(bus.rsp_valid), 0);
        step(1, 0, 3, 16'h0000, "post_rd3");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
